// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counters, RAW/WAW stall,
// flush/drain FSM and stall statistic. Optional macro SCOREBOARD_WB_BYPASS_EN enables writeback bypass.
module reg_scoreboard #(
  parameter int NREG   = 16,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_Ra,
  input  logic [IDX_W-1:0]  issue_Rb,
  input  logic [IDX_W-1:0]  issue_Rc,
  input  logic              use_Ra,
  input  logic              use_Rb,
  input  logic              use_Rc,
  input  logic              issue_regWrite,
  input  logic              wb_WE,
  input  logic [IDX_W-1:0]  wb_Rd,
  input  logic              flush_req,
  output logic              stall,
  output logic              id_en,
  output logic              bubble,
  output logic              drain_done,
  output logic              busy_err,
  output logic [STAT_W-1:0] stall_cnt
);

  localparam logic [0:0]       S_RUN   = 1'b0;
  localparam logic [0:0]       S_DRAIN = 1'b1;
  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] CONE    = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] r_pend;
  logic [0:0]                 r_state;
  logic                       r_busy_err;
  logic [STAT_W-1:0]          r_stall_cnt;

  logic w_byp_a, w_byp_b, w_byp_c;
  logic w_haz_a, w_haz_b, w_haz_c, w_haz_d, w_hazard;
  logic w_acc_wr, w_any_pend, w_err;

  // Bypass lets a retiring last write satisfy a same-cycle reader via bank write-through.
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign w_byp_a = wb_WE && (wb_Rd == issue_Ra) && (r_pend[issue_Ra] == CONE);
  assign w_byp_b = wb_WE && (wb_Rd == issue_Rb) && (r_pend[issue_Rb] == CONE);
  assign w_byp_c = wb_WE && (wb_Rd == issue_Rc) && (r_pend[issue_Rc] == CONE);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
  assign w_byp_c = 1'b0;
`endif

  assign w_haz_a  = use_Ra && (r_pend[issue_Ra] != '0) && !w_byp_a;
  assign w_haz_b  = use_Rb && (r_pend[issue_Rb] != '0) && !w_byp_b;
  assign w_haz_c  = use_Rc && (r_pend[issue_Rc] != '0) && !w_byp_c;
  assign w_haz_d  = issue_regWrite && (r_pend[issue_Rc] == CMAX);
  assign w_hazard = issue_valid && (w_haz_a || w_haz_b || w_haz_c || w_haz_d);

  assign stall      = (r_state == S_DRAIN) || flush_req || w_hazard;
  assign id_en      = !stall;
  assign bubble     = stall && issue_valid;
  assign w_acc_wr   = issue_valid && !stall && issue_regWrite;
  assign w_any_pend = |r_pend;
  assign drain_done = (r_state == S_DRAIN) && !w_any_pend && !flush_req;
  // A same-cycle accept on the same register masks the zero-count retire.
  assign w_err      = wb_WE && (r_pend[wb_Rd] == '0) && !(w_acc_wr && (issue_Rc == wb_Rd));
  assign busy_err   = r_busy_err;
  assign stall_cnt  = r_stall_cnt;

  for (genvar g = 0; g < NREG; g++) begin : g_pend
    logic w_inc, w_dec;
    assign w_inc = w_acc_wr && (issue_Rc == IDX_W'(g));
    assign w_dec = wb_WE && (wb_Rd == IDX_W'(g));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pend[g] <= '0;
      end else if (w_inc && !w_dec) begin
        r_pend[g] <= r_pend[g] + CONE;
      end else if (w_dec && !w_inc && (r_pend[g] != '0)) begin
        r_pend[g] <= r_pend[g] - CONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (flush_req) r_state <= S_DRAIN;
        S_DRAIN: if (drain_done) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_err  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_err) r_busy_err <= 1'b1;
      if (bubble && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: expectations queued at drive time, checked at negedge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_Ra, issue_Rb, issue_Rc, wb_Rd;
  logic        use_Ra, use_Rb, use_Rc, issue_regWrite, wb_WE, flush_req;
  logic        stall, id_en, bubble, drain_done, busy_err;
  logic [15:0] stall_cnt;

  typedef struct {
    string       tag;
    bit          stall;
    bit          bubble;
    bit          dd;
    bit          err;
    logic [15:0] scnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_err = 0;
  logic [15:0] m_scnt = '0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_Ra(issue_Ra), .issue_Rb(issue_Rb), .issue_Rc(issue_Rc),
    .use_Ra(use_Ra), .use_Rb(use_Rb), .use_Rc(use_Rc),
    .issue_regWrite(issue_regWrite), .wb_WE(wb_WE), .wb_Rd(wb_Rd),
    .flush_req(flush_req), .stall(stall), .id_en(id_en), .bubble(bubble),
    .drain_done(drain_done), .busy_err(busy_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".stall"},  int'(stall),      int'(e.stall));
      chk({e.tag, ".id_en"},  int'(id_en),      int'(!e.stall));
      chk({e.tag, ".bubble"}, int'(bubble),     int'(e.bubble));
      chk({e.tag, ".dd"},     int'(drain_done), int'(e.dd));
      chk({e.tag, ".err"},    int'(busy_err),   int'(e.err));
      chk({e.tag, ".scnt"},   int'(stall_cnt),  int'(e.scnt));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    issue_valid = 0; issue_Ra = 0; issue_Rb = 0; issue_Rc = 0;
    use_Ra = 0; use_Rb = 0; use_Rc = 0; issue_regWrite = 0;
    wb_WE = 0; wb_Rd = 0; flush_req = 0;
  endtask

  // Record the expected outputs for the cycle just driven and advance the model state.
  task automatic push(input string tag, input bit e_stall, input bit e_dd, input bit err_set);
    exp_t e;
    if (!rst) begin
      m_scnt = '0;
      m_err  = 0;
    end
    e.tag = tag; e.stall = e_stall; e.bubble = e_stall && issue_valid;
    e.dd = e_dd; e.err = m_err; e.scnt = m_scnt;
    q.push_back(e);
    if (rst && e.bubble && m_scnt != 16'hFFFF) m_scnt++;
    if (rst && err_set) m_err = 1;
  endtask

  task automatic wr(input logic [3:0] r);
    issue_valid = 1; issue_regWrite = 1; issue_Rc = r;
  endtask

  task automatic rda(input logic [3:0] r);
    issue_valid = 1; use_Ra = 1; issue_Ra = r;
  endtask

  task automatic ret(input logic [3:0] r);
    wb_WE = 1; wb_Rd = r;
  endtask

  initial begin
    rst = 0;
    nxt(); push("rst0", 0, 0, 0);
    nxt(); rst = 1; push("idle", 0, 0, 0);

    // RAW on R3
    nxt(); wr(3);  push("raw_wr", 0, 0, 0);
    nxt(); rda(3); push("raw_s1", 1, 0, 0);
    nxt(); rda(3); push("raw_s2", 1, 0, 0);
    nxt(); rda(3); ret(3); push("raw_wb", !BYP, 0, 0);
    nxt(); rda(3); push("raw_go", 0, 0, 0);

    // Saturation on R5
    nxt(); wr(5); push("sat_w1", 0, 0, 0);
    nxt(); wr(5); push("sat_w2", 0, 0, 0);
    nxt(); wr(5); push("sat_w3", 0, 0, 0);
    nxt(); wr(5); push("sat_w4", 1, 0, 0);
    nxt(); wr(5); ret(5); push("sat_wb", 1, 0, 0);
    nxt(); wr(5); push("sat_acc", 0, 0, 0);
    nxt(); wr(5); push("sat_full", 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); ret(5); push("sat_ret", 0, 0, 0);
    end
    nxt(); rda(5); push("sat_clr", 0, 0, 0);

    // Rb gating and store-data source
    nxt(); wr(9); push("rb_wr", 0, 0, 0);
    nxt(); issue_valid = 1; issue_Rb = 9; push("rb_imm", 0, 0, 0);
    nxt(); issue_valid = 1; issue_Rb = 9; use_Rb = 1; push("rb_use", 1, 0, 0);
    nxt(); ret(9); push("rb_ret", 0, 0, 0);
    nxt(); wr(10); push("st_wr", 0, 0, 0);
    nxt(); issue_valid = 1; use_Rc = 1; issue_Rc = 10; push("st_s", 1, 0, 0);
    nxt(); issue_valid = 1; use_Rc = 1; issue_Rc = 10; ret(10); push("st_wb", !BYP, 0, 0);
    nxt(); issue_valid = 1; use_Rc = 1; issue_Rc = 10; push("st_go", 0, 0, 0);

    // Flush / drain with two writes outstanding
    nxt(); wr(1); push("dr_w1", 0, 0, 0);
    nxt(); wr(2); push("dr_w2", 0, 0, 0);
    nxt(); rda(0); flush_req = 1; push("dr_fl", 1, 0, 0);
    nxt(); rda(0); flush_req = 1; push("dr_fl2", 1, 0, 0);
    nxt(); rda(0); ret(1); push("dr_r1", 1, 0, 0);
    nxt(); rda(0); ret(2); push("dr_r2", 1, 0, 0);
    nxt(); rda(0); flush_req = 1; push("dr_hold", 1, 0, 0);
    nxt(); rda(0); push("dr_done", 1, 1, 0);
    nxt(); rda(0); push("dr_run", 0, 0, 0);

    // Retire with zero count
    nxt(); ret(7); push("er_ret", 0, 0, 1);
    nxt(); rda(7); push("er_rd", 0, 0, 0);
    nxt(); push("er_stk", 0, 0, 0);

    // Reset mid-drain with a write outstanding
    nxt(); wr(4); push("rs_wr", 0, 0, 0);
    nxt(); rda(0); flush_req = 1; push("rs_fl", 1, 0, 0);
    nxt(); rda(4); push("rs_dr", 1, 0, 0);
    nxt(); rst = 0; rda(4); wr(4); push("rs_in", 0, 0, 0);
    nxt(); rst = 1; rda(4); push("rs_rd", 0, 0, 0);
    nxt(); push("rs_idle", 0, 0, 0);

    nxt();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("q_drain", q.size(), 0);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
